io_handshake_unit: RTL and testbench
====================================

Name: io_handshake_unit

Overview:
- Peripheral-side partner of the control core's OUTSS/INSW I/O instructions.
- Output path: latches the word the core wants shown, drives the display register and holds the request until the operator presses the confirm key, then returns a one-cycle confirmation that releases the core's stall.
- Input path: samples the switch bank on the confirm press, returns it zero-extended, and confirms.
- Includes a 2-FF key synchronizer, debounce counter and handshake FSM.

Parameters:
DATA_WIDTH, 32, width of core data path and display register
SWITCH_WIDTH, 16, number of board switches sampled on input
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized-key cycles required to accept a level change (10 ms at 50 MHz)

Ports:
clock  in  1  system clock, single domain
reset  in  1  synchronous, active-high
is_output  in  1  core requests output (OUTSS decoded); held until confirmation
is_input  in  1  core requests input (INSW decoded); held until confirmation
output_data  in  DATA_WIDTH  word to display, valid while is_output
switches  in  SWITCH_WIDTH  raw board switches, asynchronous
key_n  in  1  raw confirm key, active-low, asynchronous, bouncing
confirmation  out  1  one-cycle pulse completing the current request
input_data  out  DATA_WIDTH  switches captured at confirm, zero-extended
display_data  out  DATA_WIDTH  last word latched from output_data
waiting  out  1  high while a request awaits the operator (LED)

Behaviour:
- Reset values: confirmation=0, input_data=0, display_data=0, waiting=0; FSM=IDLE; synchronizer=released (1); debounce counter=0; debounced key=released.
- Key conditioning: key_n passes through a 2-FF synchronizer. The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the current debounced level clears the counter.
- The counter saturates; its width is clog2(DEBOUNCE_CYCLES+1).
- Press = debounced falling edge. Release = debounced rising edge.
- FSM states: IDLE, OUT_WAIT, IN_WAIT, HOLD_RELEASE, DONE.
- IDLE:
  - If is_output: latch output_data into display_data at that edge and go to OUT_WAIT.
  - Else if is_input: go to IN_WAIT.
  - Output has priority when both are high.
  - A press while IDLE is ignored.
- OUT_WAIT / IN_WAIT:
  - waiting=1.
  - On a press: IN_WAIT captures {zero pad, synchronized switches} into input_data; both states go to HOLD_RELEASE.
  - If the owning request de-asserts before the press: abort to IDLE with no confirmation; display_data is retained.
- HOLD_RELEASE:
  - waiting=1.
  - On release, go to DONE. This gives one request per physical press; a held key never auto-repeats.
- DONE:
  - confirmation=1 for exactly this cycle; waiting=0; next state IDLE.
  - Requests are ignored in DONE. A back-to-back request (next instruction also I/O) is accepted in the following IDLE cycle, so the minimum spacing between confirmations is 2 cycles plus operator time.
- Switches pass through a 2-FF synchronizer before capture. Capture latency from the press edge is 0 cycles relative to the debounced edge.
- confirmation, waiting, input_data and display_data are all registered (no combinational path from inputs).
- Reset asserted in any state: all of the above reset values apply on the next edge and the pending request is dropped. The core, reset concurrently, restarts cleanly.
- Requests must not change type mid-wait. If is_output drops and is_input rises in the same cycle in OUT_WAIT, the FSM aborts to IDLE and the input request is accepted the cycle after.

Optional Feature:
IO_AUTO_CONFIRM_EN
- Defined: adds parameter AUTO_CONFIRM_CYCLES (default 8). In OUT_WAIT/IN_WAIT, a wait counter starting at 0 on state entry goes to DONE after AUTO_CONFIRM_CYCLES cycles even without a key. IN_WAIT captures switches at that moment. A real press before expiry behaves normally. Intended for simulation and batch runs.
- Not defined: no wait counter exists; the FSM waits indefinitely for the key.

Test Plan:
- Reset hygiene: DEBOUNCE_CYCLES=4; assert reset 3 cycles mid-OUT_WAIT -> all outputs 0, FSM IDLE, no confirmation pulse afterward.
- Output handshake: is_output=1, output_data=0xDEADBEEF, press key_n low 10 cycles then release -> display_data=0xDEADBEEF one cycle after request, waiting=1 until release is debounced, single confirmation pulse 1 cycle wide, waiting=0 after.
- Input handshake: switches=0xA5C3, is_input=1, press/release -> input_data=0x0000A5C3 latched at press; later switch change to 0xFFFF does not alter input_data; exactly one confirmation.
- Debounce: key_n toggles every 2 cycles for 20 cycles (DEBOUNCE_CYCLES=4) -> no press accepted, no confirmation; then stable low 6 cycles -> press accepted.
- Priority/back-to-back: is_output and is_input both high -> OUT_WAIT taken. After confirmation, is_output held high with output_data=0x12 -> accepted in the next IDLE cycle, second confirmation needs a new press, no auto-repeat while the key is held.
- Abort: is_input drops in IN_WAIT before any press -> IDLE, confirmation never pulses, input_data unchanged (0).

Source files
------------

// File: rtl/io_handshake_unit.sv
// Operator handshake for the core's OUTSS/INSW instructions: display latch, switch capture,
// debounced confirm key. Optional macro IO_AUTO_CONFIRM_EN adds a wait-timeout auto confirm.
module io_handshake_unit #(
    parameter int DATA_WIDTH      = 32,
    parameter int SWITCH_WIDTH    = 16,
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef IO_AUTO_CONFIRM_EN
    , parameter int AUTO_CONFIRM_CYCLES = 8
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    is_output,
    input  logic                    is_input,
    input  logic [DATA_WIDTH-1:0]   output_data,
    input  logic [SWITCH_WIDTH-1:0] switches,
    input  logic                    key_n,
    output logic                    confirmation,
    output logic [DATA_WIDTH-1:0]   input_data,
    output logic [DATA_WIDTH-1:0]   display_data,
    output logic                    waiting
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, OUT_WAIT, IN_WAIT, HOLD_RELEASE, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    key_s1_q, key_s2_q, deb_q, deb_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SWITCH_WIDTH-1:0] sw_s1_q, sw_s2_q;
    logic [DATA_WIDTH-1:0]   disp_q, disp_d, inp_q, inp_d;
    logic                    conf_q, conf_d, wait_q, wait_d;
    logic                    flip, press, release_ev, timeout;

    // Debounce: flip on the cycle the disagreement reaches DEBOUNCE_CYCLES, so the
    // FSM sees the press on the same edge the debounced level changes.
    always_comb begin
        cnt_d = '0;
        flip  = 1'b0;
        if (key_s2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) flip = 1'b1;
            else if (cnt_q != CW'(DEBOUNCE_CYCLES)) cnt_d = cnt_q + 1'b1;
            else cnt_d = cnt_q;
        end
        deb_d      = flip ? ~deb_q : deb_q;
        press      = flip & deb_q;
        release_ev = flip & ~deb_q;
    end

`ifdef IO_AUTO_CONFIRM_EN
    localparam int AW = $clog2(AUTO_CONFIRM_CYCLES + 1);
    logic [AW-1:0] wcnt_q;
    assign timeout = (state_q == OUT_WAIT || state_q == IN_WAIT) &&
                     (wcnt_q == AW'(AUTO_CONFIRM_CYCLES - 1));
    always_ff @(posedge clock) begin
        if (reset || state_d != state_q) wcnt_q <= '0;
        else if (state_q == OUT_WAIT || state_q == IN_WAIT) wcnt_q <= wcnt_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        inp_d   = inp_q;
        case (state_q)
            IDLE: begin
                if (is_output) begin
                    disp_d  = output_data;
                    state_d = OUT_WAIT;
                end else if (is_input) begin
                    state_d = IN_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!is_output)   state_d = IDLE;
                else if (press)   state_d = HOLD_RELEASE;
                else if (timeout) state_d = DONE;
            end
            IN_WAIT: begin
                if (!is_input) begin
                    state_d = IDLE;
                end else if (press || timeout) begin
                    inp_d   = DATA_WIDTH'(sw_s2_q);
                    state_d = press ? HOLD_RELEASE : DONE;
                end
            end
            HOLD_RELEASE: if (release_ev) state_d = DONE;
            DONE:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase
        wait_d = (state_d == OUT_WAIT) || (state_d == IN_WAIT) || (state_d == HOLD_RELEASE);
        conf_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            deb_q    <= 1'b1;
            cnt_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            disp_q   <= '0;
            inp_q    <= '0;
            conf_q   <= 1'b0;
            wait_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_s1_q <= key_n;
            key_s2_q <= key_s1_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            disp_q   <= disp_d;
            inp_q    <= inp_d;
            conf_q   <= conf_d;
            wait_q   <= wait_d;
        end
    end

    assign confirmation = conf_q;
    assign waiting      = wait_q;
    assign display_data = disp_q;
    assign input_data   = inp_q;
endmodule

// File: tb/tb_io_handshake_unit.sv
// Scoreboard bench for io_handshake_unit: expected display/input words are queued per
// request and compared when the confirmation pulse appears.
module tb_io_handshake_unit;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int DB = 4;

    logic          clock = 1'b0;
    logic          reset, is_output, is_input, key_n;
    logic [DW-1:0] output_data;
    logic [SW-1:0] switches;
    logic          confirmation, waiting;
    logic [DW-1:0] input_data, display_data;

    typedef struct {
        logic [DW-1:0] disp;
        logic [DW-1:0] inp;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0, n_pass = 0, conf_cnt = 0, c0;

    io_handshake_unit #(.DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .DEBOUNCE_CYCLES(DB)) dut (
        .clock(clock), .reset(reset), .is_output(is_output), .is_input(is_input),
        .output_data(output_data), .switches(switches), .key_n(key_n),
        .confirmation(confirmation), .input_data(input_data),
        .display_data(display_data), .waiting(waiting)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Returns at the negedge inside the DONE cycle, or flags a timeout.
    task automatic wait_conf(input string tag);
        bit got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (confirmation === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && confirmation === 1'b1) begin
            conf_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_conf", 1, 0);
            end else begin
                e = q.pop_front();
                chk("conf_display", display_data, e.disp);
                chk("conf_input", input_data, e.inp);
            end
        end
    end

    initial begin
        reset = 1'b1; is_output = 1'b0; is_input = 1'b0; key_n = 1'b1;
        output_data = '0; switches = '0;
        cycles(3);
        chk("rst_conf", confirmation, 0);
        chk("rst_wait", waiting, 0);
        chk("rst_disp", display_data, 0);
        chk("rst_inp", input_data, 0);
        reset = 1'b0;
        cycles(2);

        // abort: input request withdrawn before any press
        is_input = 1'b1;
        cycles(3);
        chk("abort_wait_hi", waiting, 1);
        is_input = 1'b0;
        cycles(3);
        chk("abort_wait_lo", waiting, 0);
        chk("abort_inp", input_data, 0);

        // reset in the middle of OUT_WAIT
        is_output = 1'b1; output_data = 32'h0000CAFE;
        cycles(2);
        chk("rh_disp_latched", display_data, 32'h0000CAFE);
        reset = 1'b1; is_output = 1'b0;
        cycles(3);
        chk("rh_disp", display_data, 0);
        chk("rh_wait", waiting, 0);
        chk("rh_conf", confirmation, 0);
        reset = 1'b0;
        key_n = 1'b0; cycles(10); key_n = 1'b1; cycles(12);
        chk("rh_no_conf", conf_cnt, 0);
        chk("rh_idle_wait", waiting, 0);

        // output handshake
        is_output = 1'b1; output_data = 32'hDEADBEEF;
        q.push_back('{32'hDEADBEEF, 32'h0});
        cycles(1);
        chk("out_disp", display_data, 32'hDEADBEEF);
        chk("out_wait", waiting, 1);
        key_n = 1'b0; cycles(10);
        chk("out_wait_held", waiting, 1);
        key_n = 1'b1;
        wait_conf("out");
        is_output = 1'b0;
        cycles(1);
        chk("out_pulse_width", confirmation, 0);
        chk("out_wait_after", waiting, 0);

        // input handshake
        switches = 16'hA5C3;
        cycles(3);
        is_input = 1'b1;
        q.push_back('{32'hDEADBEEF, 32'h0000A5C3});
        cycles(2);
        key_n = 1'b0; cycles(10);
        switches = 16'hFFFF;
        cycles(3);
        key_n = 1'b1;
        wait_conf("in");
        is_input = 1'b0;
        cycles(3);
        chk("in_hold", input_data, 32'h0000A5C3);
        chk("in_one_conf", conf_cnt, 2);

        // debounce: bouncing key must be rejected, 6 stable low cycles accepted
        is_output = 1'b1; output_data = 32'h55;
        q.push_back('{32'h55, 32'h0000A5C3});
        c0 = conf_cnt;
        for (int i = 0; i < 10; i++) begin
            key_n = i[0];
            cycles(2);
        end
        key_n = 1'b1;
        cycles(10);
        chk("deb_no_press", conf_cnt, c0);
        chk("deb_still_wait", waiting, 1);
        key_n = 1'b0; cycles(6); key_n = 1'b1;
        wait_conf("deb");
        is_output = 1'b0;
        cycles(2);

        // priority, then back-to-back output while key is held
        is_output = 1'b1; is_input = 1'b1; output_data = 32'h77;
        q.push_back('{32'h77, 32'h0000A5C3});
        cycles(1);
        chk("prio_out_taken", display_data, 32'h77);
        key_n = 1'b0; cycles(10); key_n = 1'b1;
        wait_conf("prio");
        is_input = 1'b0; output_data = 32'h12;
        q.push_back('{32'h12, 32'h0000A5C3});
        cycles(1);
        chk("b2b_idle_disp", display_data, 32'h77);
        cycles(1);
        chk("b2b_accept", display_data, 32'h12);
        chk("b2b_wait", waiting, 1);
        c0 = conf_cnt;
        key_n = 1'b0; cycles(25);
        chk("no_autorepeat", conf_cnt, c0);
        chk("held_wait", waiting, 1);
        key_n = 1'b1;
        wait_conf("b2b");
        is_output = 1'b0;
        cycles(3);

        chk("total_conf", conf_cnt, 5);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
